// File: rtl/test_pkg.sv
// Shared definitions for the test_rx packet checker.
// State encoding is an enum when SIM_FSM is defined, otherwise plain localparams.
package test_pkg;

    localparam logic [15:0] SCR_INIT_DEFAULT = 16'h55AA;

    localparam int unsigned PKT_CNT_W  = 32;
    localparam int unsigned DATA_ERR_W = 32;
    localparam int unsigned LEN_ERR_W  = 16;
    localparam int unsigned BEAT_W     = 16;

`ifdef SIM_FSM
    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        CHECK = 2'd1,
        GAP   = 2'd2
    } state_t;
`else
    typedef logic [1:0] state_t;
    localparam state_t HUNT  = 2'd0;
    localparam state_t CHECK = 2'd1;
    localparam state_t GAP   = 2'd2;
`endif

    // Counters never wrap: an overflowing add sticks at all-ones.
    function automatic logic [31:0] sat_add32(input logic [31:0] v, input logic [1:0] inc);
        logic [32:0] s;
        s = {1'b0, v} + {31'b0, inc};
        return s[32] ? '1 : s[31:0];
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] v, input logic [1:0] inc);
        logic [16:0] s;
        s = {1'b0, v} + {15'b0, inc};
        return s[16] ? '1 : s[15:0];
    endfunction

endpackage

// File: rtl/sata_scrambler.sv
// SATA payload scrambler: 16-bit LFSR (x^16+x^15+x^13+x^4+1), 32 bits per step.
// p_in_SOF reloads the seed (priority over p_in_en); p_in_en advances one word.
module sata_scrambler #(
    parameter logic [15:0] G_INIT_VAL = 16'hF0F6
) (
    input  logic        p_in_clk,
    input  logic        p_in_rst_n,
    input  logic        p_in_SOF,
    input  logic        p_in_en,
    output logic [31:0] p_out_result
);

    logic [15:0] lfsr;
    logic [15:0] lfsr_nxt;

    always_comb begin
        logic [15:0] s;
        s = lfsr;
        p_out_result = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            p_out_result[i] = s[15] ^ s[14] ^ s[12] ^ s[3];
            s = {s[14:0], p_out_result[i]};
        end
        lfsr_nxt = s;
    end

    always_ff @(posedge p_in_clk or negedge p_in_rst_n) begin
        if (!p_in_rst_n)
            lfsr <= G_INIT_VAL;
        else if (p_in_SOF)
            lfsr <= G_INIT_VAL;
        else if (p_in_en)
            lfsr <= lfsr_nxt;
    end

endmodule

// File: rtl/test_rx.sv
// Receive-side checker for the scrambled test-packet stream: data, length and framing.
// Define TEST_RX_RESYNC_EN to fall back to HUNT after 4 consecutive data-errored packets.
module test_rx
    import test_pkg::*;
#(
    parameter int unsigned TEST_DATA_WIDTH = 32,
    parameter logic [15:0] SCR_INIT_VAL    = SCR_INIT_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [TEST_DATA_WIDTH-1:0] mac_rx_data,
    input  logic                       mac_rx_valid,
    input  logic                       mac_rx_sof,
    input  logic                       mac_rx_eof,
    input  logic [15:0]                pkt_size,
    input  logic                       clr,
    output logic                       synced,
    output logic [PKT_CNT_W-1:0]       pkt_cnt,
    output logic [DATA_ERR_W-1:0]      err_data_cnt,
    output logic [LEN_ERR_W-1:0]       err_len_cnt,
    output logic                       err,
    output logic                       err_stb
);

    state_t              state, state_n;
    logic [BEAT_W-1:0]   beat_cnt, beat_n;
    logic [15:0]         size_q, size_n;
    logic                pkt_err, pkt_err_n;
    logic [1:0]          len_inc, pkt_inc;
    logic                data_err, advance, start, pkt_end, resync, stb_n;
    logic [31:0]         scr_word;
    logic                match;
`ifdef TEST_RX_RESYNC_EN
    logic [3:0]          bad_run, bad_run_n;
`endif

    sata_scrambler #(
        .G_INIT_VAL (SCR_INIT_VAL)
    ) u_scr (
        .p_in_clk     (clk),
        .p_in_rst_n   (rst),
        .p_in_SOF     (clr | resync),
        .p_in_en      (advance & ~clr),
        .p_out_result (scr_word)
    );

    assign match = (mac_rx_data == scr_word[TEST_DATA_WIDTH-1:0]);

    always_comb begin
        state_n   = state;
        beat_n    = beat_cnt;
        size_n    = size_q;
        pkt_err_n = pkt_err;
        len_inc   = '0;
        pkt_inc   = '0;
        data_err  = 1'b0;
        advance   = 1'b0;
        start     = 1'b0;
        pkt_end   = 1'b0;
        resync    = 1'b0;
        if (mac_rx_valid) begin
            case (state)
                HUNT: start = mac_rx_sof && match;
                CHECK: begin
                    advance  = 1'b1;
                    data_err = !match;
                    // sof without eof closes the open packet as a framing error
                    if (mac_rx_sof) begin
                        start   = 1'b1;
                        len_inc = 2'd1;
                        pkt_inc = 2'd1;
                    end else begin
                        beat_n    = sat_add16(beat_cnt, 2'd1);
                        pkt_err_n = pkt_err | !match;
                    end
                end
                GAP: begin
                    advance = 1'b1;
                    if (mac_rx_sof) begin
                        start    = 1'b1;
                        data_err = !match;
                    end else begin
                        len_inc = 2'd1;
                    end
                end
                default: state_n = HUNT;
            endcase
            if (start) begin
                advance   = 1'b1;
                beat_n    = 16'd1;
                size_n    = pkt_size;
                pkt_err_n = !match;
                state_n   = CHECK;
            end
            if (mac_rx_eof && (start || state == CHECK)) begin
                pkt_end = 1'b1;
                pkt_inc = pkt_inc + 2'd1;
                if (beat_n != size_n)
                    len_inc = len_inc + 2'd1;
                state_n = GAP;
            end
        end
`ifdef TEST_RX_RESYNC_EN
        bad_run_n = bad_run;
        if (pkt_end) begin
            if (!pkt_err_n) begin
                bad_run_n = '0;
            end else if (bad_run == 4'd3) begin
                resync    = 1'b1;
                bad_run_n = '0;
                state_n   = HUNT;
            end else begin
                bad_run_n = bad_run + 4'd1;
            end
        end
`endif
        stb_n = data_err || (len_inc != 2'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= HUNT;
            beat_cnt     <= '0;
            size_q       <= '0;
            pkt_err      <= 1'b0;
            synced       <= 1'b0;
            pkt_cnt      <= '0;
            err_data_cnt <= '0;
            err_len_cnt  <= '0;
            err          <= 1'b0;
            err_stb      <= 1'b0;
`ifdef TEST_RX_RESYNC_EN
            bad_run      <= '0;
`endif
        end else if (clr) begin
            state        <= HUNT;
            beat_cnt     <= '0;
            size_q       <= '0;
            pkt_err      <= 1'b0;
            synced       <= 1'b0;
            pkt_cnt      <= '0;
            err_data_cnt <= '0;
            err_len_cnt  <= '0;
            err          <= 1'b0;
            err_stb      <= 1'b0;
`ifdef TEST_RX_RESYNC_EN
            bad_run      <= '0;
`endif
        end else begin
            state        <= state_n;
            beat_cnt     <= beat_n;
            size_q       <= size_n;
            pkt_err      <= pkt_err_n;
            synced       <= (state_n != HUNT);
            pkt_cnt      <= sat_add32(pkt_cnt, pkt_inc);
            err_data_cnt <= sat_add32(err_data_cnt, {1'b0, data_err});
            err_len_cnt  <= sat_add16(err_len_cnt, len_inc);
            err          <= err | stb_n;
            err_stb      <= stb_n;
`ifdef TEST_RX_RESYNC_EN
            bad_run      <= bad_run_n;
`endif
        end
    end

endmodule

// File: tb/tb_test_rx.sv
// Directed bench for test_rx: local scrambled-packet source and hand-computed counter values.
module tb_test_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] mac_rx_data = '0;
    logic        mac_rx_valid = 1'b0;
    logic        mac_rx_sof = 1'b0;
    logic        mac_rx_eof = 1'b0;
    logic [15:0] pkt_size = 16'd16;
    logic        clr = 1'b0;
    logic        synced;
    logic [31:0] pkt_cnt;
    logic [31:0] err_data_cnt;
    logic [15:0] err_len_cnt;
    logic        err;
    logic        err_stb;

    int total = 0;
    int bad = 0;
    logic [15:0] tx_lfsr = 16'h55AA;

    test_rx #(
        .TEST_DATA_WIDTH (32),
        .SCR_INIT_VAL    (16'h55AA)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mac_rx_data  (mac_rx_data),
        .mac_rx_valid (mac_rx_valid),
        .mac_rx_sof   (mac_rx_sof),
        .mac_rx_eof   (mac_rx_eof),
        .pkt_size     (pkt_size),
        .clr          (clr),
        .synced       (synced),
        .pkt_cnt      (pkt_cnt),
        .err_data_cnt (err_data_cnt),
        .err_len_cnt  (err_len_cnt),
        .err          (err),
        .err_stb      (err_stb)
    );

    always #5 clk = ~clk;

    // Transmitter model: taps 15,14,12,3 as a parity mask, LSB-first word assembly.
    function automatic logic [31:0] tx_word(input logic [15:0] s);
        logic b;
        tx_word = '0;
        for (int i = 0; i < 32; i++) begin
            b = ^(s & 16'hD008);
            tx_word[i] = b;
            s = {s[14:0], b};
        end
    endfunction

    function automatic logic [15:0] tx_next(input logic [15:0] s);
        logic b;
        for (int i = 0; i < 32; i++) begin
            b = ^(s & 16'hD008);
            s = {s[14:0], b};
        end
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic expect_cnts(input string tag, input int p, input int d, input int l,
                               input bit sy, input bit er);
        chk({tag, ".pkt"}, pkt_cnt, p);
        chk({tag, ".data"}, err_data_cnt, d);
        chk({tag, ".len"}, {16'b0, err_len_cnt}, l);
        chk({tag, ".synced"}, {31'b0, synced}, {31'b0, sy});
        chk({tag, ".err"}, {31'b0, err}, {31'b0, er});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mac_rx_valid = 1'b0;
            mac_rx_sof   = 1'b0;
            mac_rx_eof   = 1'b0;
        end
    endtask

    task automatic send_pkt(input int n, input int flip, input bit with_sof, input bit with_eof);
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (flip >= 0 && i == flip + 1) chk("stb_hi", {31'b0, err_stb}, 32'd1);
            if (flip >= 0 && i == flip + 2) chk("stb_lo", {31'b0, err_stb}, 32'd0);
            w = tx_word(tx_lfsr);
            tx_lfsr = tx_next(tx_lfsr);
            if (i == flip) w[0] = ~w[0];
            mac_rx_data  = w;
            mac_rx_valid = 1'b1;
            mac_rx_sof   = with_sof && (i == 0);
            mac_rx_eof   = with_eof && (i == n - 1);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        expect_cnts("reset", 0, 0, 0, 1'b0, 1'b0);
        chk("reset.stb", {31'b0, err_stb}, 32'd0);
        rst = 1'b1;
        idle(2);

        // clean stream
        for (int p = 0; p < 10; p++) begin
            send_pkt(16, -1, 1'b1, 1'b1);
            idle(4);
        end
        expect_cnts("clean", 10, 0, 0, 1'b1, 1'b0);

        // bit 0 flipped on beat 5
        send_pkt(16, 4, 1'b1, 1'b1);
        idle(4);
        expect_cnts("flip", 11, 1, 0, 1'b1, 1'b1);

        // checker expects 15 beats, transmitter sends 16
        pkt_size = 16'd15;
        send_pkt(16, -1, 1'b1, 1'b1);
        idle(1);
        chk("len.stb", {31'b0, err_stb}, 32'd1);
        idle(3);
        send_pkt(16, -1, 1'b1, 1'b1);
        idle(4);
        send_pkt(16, -1, 1'b1, 1'b1);
        idle(4);
        expect_cnts("len15", 14, 1, 3, 1'b1, 1'b1);

        // single-beat packets: size 1 is clean, size 0 is a length error
        pkt_size = 16'd1;
        send_pkt(1, -1, 1'b1, 1'b1);
        idle(1);
        chk("one.stb", {31'b0, err_stb}, 32'd0);
        idle(3);
        expect_cnts("one", 15, 1, 3, 1'b1, 1'b1);
        pkt_size = 16'd0;
        send_pkt(1, -1, 1'b1, 1'b1);
        idle(4);
        expect_cnts("zero", 16, 1, 4, 1'b1, 1'b1);

        // eof dropped: next sof closes the packet as a framing error
        pkt_size = 16'd16;
        send_pkt(16, -1, 1'b1, 1'b0);
        idle(4);
        send_pkt(16, -1, 1'b1, 1'b1);
        idle(4);
        expect_cnts("noeof", 18, 1, 5, 1'b1, 1'b1);

        // stray beat in the gap
        send_pkt(1, -1, 1'b0, 1'b0);
        idle(1);
        chk("stray.stb", {31'b0, err_stb}, 32'd1);
        idle(3);
        send_pkt(16, -1, 1'b1, 1'b1);
        idle(4);
        expect_cnts("stray", 19, 1, 6, 1'b1, 1'b1);

        // clr mid-packet: back to HUNT, unseeded packets ignored, seeded one relocks
        send_pkt(5, -1, 1'b1, 1'b0);
        @(negedge clk);
        mac_rx_valid = 1'b0;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        expect_cnts("clr", 0, 0, 0, 1'b0, 1'b0);
        send_pkt(11, -1, 1'b0, 1'b1);
        idle(4);
        send_pkt(16, -1, 1'b1, 1'b1);
        idle(4);
        expect_cnts("hunt", 0, 0, 0, 1'b0, 1'b0);
        tx_lfsr = 16'h55AA;
        send_pkt(16, -1, 1'b1, 1'b1);
        idle(4);
        expect_cnts("relock", 1, 0, 0, 1'b1, 1'b0);

        // asynchronous reset mid-packet
        send_pkt(3, -1, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        mac_rx_valid = 1'b0;
        #1;
        expect_cnts("arst", 0, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        tx_lfsr = 16'h55AA;
        send_pkt(16, -1, 1'b1, 1'b1);
        idle(4);
        expect_cnts("arst_relock", 1, 0, 0, 1'b1, 1'b0);

        // transmitter restart: every beat mismatches until resync (if enabled)
        tx_lfsr = 16'h55AA;
`ifdef TEST_RX_RESYNC_EN
        for (int p = 0; p < 3; p++) begin
            send_pkt(16, -1, 1'b1, 1'b1);
            idle(4);
        end
        expect_cnts("restart3", 4, 48, 0, 1'b1, 1'b1);
        send_pkt(16, -1, 1'b1, 1'b1);
        idle(4);
        expect_cnts("resync", 5, 64, 0, 1'b0, 1'b1);
        tx_lfsr = 16'h55AA;
        send_pkt(16, -1, 1'b1, 1'b1);
        idle(4);
        expect_cnts("resync_lock", 6, 64, 0, 1'b1, 1'b1);
`else
        for (int p = 0; p < 2; p++) begin
            send_pkt(16, -1, 1'b1, 1'b1);
            idle(4);
        end
        expect_cnts("restart", 3, 32, 0, 1'b1, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/test_rx.md
Name: test_rx

Overview:
- Receive-side checker for the scrambled test-packet stream produced by the team's test packet generator. It sits on the MAC RX user interface.
- Regenerates the expected payload with a local sata_scrambler seeded to the same value and checks every beat against it.
- Also checks packet framing (sof/eof) and packet length.
- Exposes packet, data-error and length/framing-error counters plus a sticky error flag for link BER tests.

Parameters:
- TEST_DATA_WIDTH, 32, compared data width; legal range 1..32; only bits [TEST_DATA_WIDTH-1:0] of the scrambler word are used.
- SCR_INIT_VAL, 16'h55AA, scrambler seed; must match the transmitter.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  reset: asynchronous assert, active-low.
- mac_rx_data  in  TEST_DATA_WIDTH  received beat.
- mac_rx_valid  in  1  beat qualifier.
- mac_rx_sof  in  1  first beat of packet; meaningful only when valid=1.
- mac_rx_eof  in  1  last beat of packet; meaningful only when valid=1.
- pkt_size  in  16  expected beats per packet; sampled at each accepted sof.
- clr  in  1  synchronous clear of counters and sticky flag; also re-enters HUNT.
- synced  out  1  1 = local scrambler is aligned to the stream.
- pkt_cnt  out  32  packets completed, good or bad.
- err_data_cnt  out  32  beats whose data mismatched.
- err_len_cnt  out  16  length or framing errors.
- err  out  1  sticky; set on any error; cleared by clr or reset.
- err_stb  out  1  one-cycle pulse for each errored beat or errored packet end.

Behaviour:
Reset and clear:
- Reset asserted: every output is 0, state is HUNT, beat counter is 0, and the scrambler is reseeded to SCR_INIT_VAL.
- clr=1: the same actions as reset, applied synchronously. clr has priority over any beat in the same cycle.

Comparison:
- exp = scrambler output [TEST_DATA_WIDTH-1:0].
- The compare is combinational against mac_rx_data; the result is registered.
- Counters and flags update 1 cycle after the beat; this is the fixed latency.
- The scrambler advances exactly once per accepted valid beat while not in HUNT. It is never reseeded per packet, because the transmitter seeds only once per start.

States:
- HUNT:
  - Scrambler is held at the seed; synced=0.
  - A beat with valid & sof & data==exp moves to CHECK, advances the scrambler and sets beat count to 1.
  - Any other beat is ignored, with no counter change.
- CHECK:
  - Each valid beat increments the beat count (saturating at 16'hFFFF).
  - On data!=exp: err_data_cnt++, err_stb, err set.
  - On eof: pkt_cnt++; if the beat count including this beat != pkt_size_latched, then err_len_cnt++ and err_stb. Next state is GAP.
  - eof on the same beat as sof (1-beat packet) is legal and is length-checked against pkt_size.
  - sof arriving in CHECK without a preceding eof: framing error (err_len_cnt++). The packet is closed (pkt_cnt++), a new packet starts on this beat with count=1, and the beat's data is still compared.
- GAP:
  - valid & sof moves to CHECK with compare and count=1.
  - A valid beat without sof is a framing error (err_len_cnt++). The beat still advances the scrambler, its data is not compared, and the state stays GAP.

Arithmetic and counters:
- All counters saturate at their all-ones value; they never wrap.
- pkt_size=0 or 1 are legal. A size of 0 always produces a length error.
- valid=0 cycles never advance anything, in any state.
- synced=1 in CHECK and GAP.

Optional Feature:
- Macro: TEST_RX_RESYNC_EN.
- With the macro defined:
  - A 4-bit counter counts consecutive packets containing one or more data errors.
  - When it reaches 4, the block returns to HUNT and reseeds on the cycle after the 4th errored eof.
  - A clean packet zeroes the counter.
  - This allows recovery after a transmitter restart, which reseeds.
- Without the macro: the block never leaves CHECK/GAP except through reset or clr.

Decomposition:
- Package test_pkg holds:
  - the FSM state encoding (HUNT=2'd0, CHECK=2'd1, GAP=2'd2), with the enum under SIM_FSM and localparams otherwise;
  - the constant SCR_INIT_DEFAULT=16'h55AA;
  - the counter widths.
- Sub-module: the existing sata_scrambler, instantiated once. Its p_in_SOF is driven by the seed pulse (reset, clr or resync) and its p_in_en by the advance condition.
- No other sub-module.

Test Plan:
- Loopback from the test packet generator, pkt_size=16, pause_size=4, 100 packets -> pkt_cnt=100, err_data_cnt=0, err_len_cnt=0, synced=1, err=0.
- Same stream with bit 0 flipped on beat 5 of packet 10 -> err_data_cnt=1, one err_stb exactly 1 cycle after that beat, err=1, pkt_cnt=100.
- Transmitter pkt_size=16 but checker pkt_size=15 -> err_len_cnt equals packet count and err_data_cnt=0; a 1-beat packet (sof&eof) with pkt_size=1 passes.
- eof of packet 3 dropped -> err_len_cnt=1; packet 4 data still clean; pkt_cnt stays consistent.
- Assert clr mid-packet, then reset low mid-packet -> outputs zero immediately on reset; state HUNT; relock on the next packet only if its first word equals the seed output.
- With TEST_RX_RESYNC_EN: restart the transmitter (reseed) mid-run -> 4 errored packets, return to HUNT, lock on the next seeded sof, then 0 further errors. Without the macro -> errors persist on every packet.
